// File: rtl/phy_tx_nlane_if.sv
// Word-source handshake into the multi-lane PHY transmit path.
// The source drives data_in/valid_in and must hold the word until ready_out is seen high.
interface phy_tx_nlane_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/phy_tx_nlane.sv
// Multi-lane PHY transmit path on a single bit-rate clock.
// Words are buffered in a FIFO and striped round-robin across the lanes once per 32-bit frame;
// every lane shifts its word out MSB-first and sends idle fill when it has no data.
module phy_tx_nlane #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_32f,
  input  logic              reset,
  phy_tx_nlane_if.slave     wr,
  output logic [LANES-1:0]  data_out,
  output logic [LANES-1:0]  lane_valid,
  output logic              frame_start,
  output logic [CntW-1:0]   fifo_count
);

  // A depth of one still needs a one-bit pointer; the modulo below keeps it at zero.
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] IdleWord = {4{IDLE_BYTE}};

  logic [4:0]      bit_cnt_q;
  logic            boundary;
  logic            push;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] take;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem_q [FIFO_DEPTH];

  // The frame-boundary edge is the one leaving bit 31; loads happen there.
  assign boundary    = (bit_cnt_q == 5'd31);
  assign frame_start = (bit_cnt_q == 5'd0);
  assign fifo_count  = count_q;

  // Ready comes only from the registered count, so a same-cycle pop never raises it.
  assign wr.ready_out = (count_q != CntW'(FIFO_DEPTH));
  assign push         = wr.valid_in && wr.ready_out;

  // Words handed to the lanes this edge: min(count, LANES) on the boundary, else none.
  always_comb begin
    take = '0;
    if (boundary) begin
      take = (count_q < CntW'(LANES)) ? count_q : CntW'(LANES);
    end
  end

  // Next-state for pointers and occupancy; a boundary push is counted but not loaded.
  always_comb begin
    rd_ptr_d = PtrW'((32'(rd_ptr_q) + 32'(take)) % FIFO_DEPTH);
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = PtrW'((32'(wr_ptr_q) + 32'd1) % FIFO_DEPTH);
    end
    count_d = count_q + CntW'(push) - take;
  end

  // Frame counter and FIFO bookkeeping.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt_q <= 5'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 5'd1;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.data_in;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0]     shreg_q;
    logic            valid_q;
    logic            lane_take;
    logic [PtrW-1:0] rd_idx;

    // Lane i always takes the i-th oldest word, so the round-robin restarts at lane 0 per frame.
    assign rd_idx    = PtrW'((32'(rd_ptr_q) + 32'(i)) % FIFO_DEPTH);
    assign lane_take = (CntW'(i) < take);

    // Load a data or idle word at the boundary, otherwise shift out MSB-first.
    always_ff @(posedge clk_32f) begin
      if (reset) begin
        shreg_q <= IdleWord;
        valid_q <= 1'b0;
      end else if (boundary) begin
        shreg_q <= lane_take ? mem_q[rd_idx] : IdleWord;
        valid_q <= lane_take;
      end else begin
        shreg_q <= {shreg_q[30:0], 1'b0};
      end
    end

    assign data_out[i]   = shreg_q[31];
    assign lane_valid[i] = valid_q;
  end

endmodule

// File: tb/tb_phy_tx_nlane.sv
// Bench for phy_tx_nlane: a 2-lane/8-deep and a 4-lane/16-deep instance run in lockstep.
// A reference model checks every cycle; directed sequences check framed words by value.
module tb_phy_tx_nlane;

  localparam logic [31:0] IdleW = 32'hBCBC_BCBC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phy_tx_nlane_if if2 ();
  phy_tx_nlane_if if4 ();

  logic [1:0] dout2, lv2;
  logic       fs2;
  logic [3:0] cnt2;
  logic [3:0] dout4, lv4;
  logic       fs4;
  logic [4:0] cnt4;

  phy_tx_nlane #(.LANES(2), .FIFO_DEPTH(8), .IDLE_BYTE(8'hBC)) u_dut2 (
    .clk_32f     (clk),
    .reset       (rst),
    .wr          (if2),
    .data_out    (dout2),
    .lane_valid  (lv2),
    .frame_start (fs2),
    .fifo_count  (cnt2)
  );

  phy_tx_nlane #(.LANES(4), .FIFO_DEPTH(16), .IDLE_BYTE(8'hBC)) u_dut4 (
    .clk_32f     (clk),
    .reset       (rst),
    .wr          (if4),
    .data_out    (dout4),
    .lane_valid  (lv4),
    .frame_start (fs4),
    .fifo_count  (cnt4)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic [7:0]  cnt;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] sbq [2][$];  // words accepted, awaiting a frame load
  logic [31:0] src [2][$];  // words the source still has to hand over
  logic [31:0] ew  [2][4];  // words expected on the lanes this frame
  logic [3:0]  ev  [2];
  logic [31:0] cw  [2][4];  // words captured from the lanes
  logic [3:0]  cv  [2];
  int          mbit;
  int          n_vec;
  int          n_err;

  function automatic int nl(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int dep(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, update the model after the rising edge,
  // then compare both DUTs against the model at the next falling edge.
  task automatic cyc(input logic r, input logic v0, input logic [31:0] x0,
                     input logic v1, input logic [31:0] x1,
                     output logic a0, output logic a1);
    logic        va  [2];
    logic [31:0] xa  [2];
    logic        acc [2];
    logic [17:0] ex, ac;
    int          k;
    rst = r;
    if2.valid_in = v0;
    if2.data_in  = x0;
    if4.valid_in = v1;
    if4.data_in  = x1;
    va[0] = v0; va[1] = v1;
    xa[0] = x0; xa[1] = x1;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = 1'b0;
      if (r) begin
        sbq[d].delete();
        ev[d] = '0;
        for (int l = 0; l < 4; l++) ew[d][l] = IdleW;
      end else begin
        acc[d] = va[d] && (sbq[d].size() != dep(d));
        if (mbit == 31) begin
          k = (sbq[d].size() < nl(d)) ? sbq[d].size() : nl(d);
          for (int l = 0; l < 4; l++) begin
            if (l < k) begin
              ew[d][l] = sbq[d].pop_front();
              ev[d][l] = 1'b1;
            end else begin
              ew[d][l] = IdleW;
              ev[d][l] = 1'b0;
            end
          end
        end
        if (acc[d]) sbq[d].push_back(xa[d]);
      end
    end
    mbit = r ? 0 : (mbit + 1) % 32;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ex        = '0;
      ex[17]    = (sbq[d].size() != dep(d));
      ex[16:9]  = 8'(sbq[d].size());
      ex[8]     = (mbit == 0);
      for (int l = 0; l < nl(d); l++) begin
        ex[4+l] = ev[d][l];
        ex[l]   = ew[d][l][31-mbit];
      end
      if (d == 0) begin
        ac = {if2.ready_out, 8'(cnt2), fs2, 4'(lv2), 4'(dout2)};
        chk($sformatf("cycle_l2_bit%0d", mbit), 64'(ac), 64'(ex));
      end else begin
        ac = {if4.ready_out, 8'(cnt4), fs4, lv4, dout4};
        chk($sformatf("cycle_l4_bit%0d", mbit), 64'(ac), 64'(ex));
      end
    end
    a0 = acc[0];
    a1 = acc[1];
  endtask

  task automatic do_reset();
    logic a0, a1;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a0, a1);
  endtask

  // Source behaviour: present the head word and hold it until accepted.
  task automatic step();
    logic        v [2];
    logic [31:0] x [2];
    logic        a0, a1;
    for (int d = 0; d < 2; d++) begin
      v[d] = (src[d].size() > 0);
      x[d] = v[d] ? src[d][0] : 32'h0;
    end
    cyc(1'b0, v[0], x[0], v[1], x[1], a0, a1);
    if (a0) void'(src[0].pop_front());
    if (a1) void'(src[1].pop_front());
  endtask

  task automatic run_to(input int b);
    for (int i = 0; i < 32; i++) begin
      if (mbit == b) break;
      step();
    end
  endtask

  // Advance through the next frame boundary and record the full frame on every lane.
  task automatic capture();
    run_to(31);
    step();
    for (int j = 0; j < 32; j++) begin
      if (j > 0) step();
      if (j == 0) begin
        cv[0] = 4'(lv2);
        cv[1] = lv4;
      end
      for (int l = 0; l < 2; l++) cw[0][l][31-j] = dout2[l];
      for (int l = 0; l < 4; l++) cw[1][l][31-j] = dout4[l];
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mbit  = 0;
    rst   = 1'b1;
    if2.valid_in = 1'b0; if2.data_in = 32'h0;
    if4.valid_in = 1'b0; if4.data_in = 32'h0;
    for (int l = 0; l < 4; l++) begin
      cw[0][l] = '0;
      cw[1][l] = '0;
    end

    tbl[0] = '{1'b1, 32'h1111_0000, 1'b1, 8'd1};
    tbl[1] = '{1'b1, 32'h1111_0001, 1'b1, 8'd2};
    tbl[2] = '{1'b1, 32'h1111_0002, 1'b1, 8'd3};
    tbl[3] = '{1'b1, 32'h1111_0003, 1'b1, 8'd4};
    tbl[4] = '{1'b1, 32'h1111_0004, 1'b1, 8'd5};
    tbl[5] = '{1'b1, 32'h1111_0005, 1'b1, 8'd6};
    tbl[6] = '{1'b1, 32'h1111_0006, 1'b1, 8'd7};
    tbl[7] = '{1'b1, 32'h1111_0007, 1'b0, 8'd8};
    tbl[8] = '{1'b1, 32'h1111_0008, 1'b0, 8'd8};
    tbl[9] = '{1'b1, 32'h1111_0008, 1'b0, 8'd8};

    @(negedge clk);
    do_reset();
    do_reset();
    chk("reset_l2", 64'({if2.ready_out, 8'(cnt2), fs2, lv2, dout2}),
        64'({1'b1, 8'd0, 1'b1, 2'b00, 2'b11}));
    chk("reset_l4", 64'({if4.ready_out, 8'(cnt4), fs4, lv4, dout4}),
        64'({1'b1, 8'd0, 1'b1, 4'b0000, 4'b1111}));

    // Idle line for two frames.
    for (int f = 0; f < 2; f++) begin
      capture();
      chk("idle_lane0", 64'(cw[0][0]), 64'(IdleW));
      chk("idle_lane1", 64'(cw[0][1]), 64'(IdleW));
      chk("idle_valid", 64'(cv[0]), 64'(0));
    end

    // Two words striped across both lanes.
    step();
    src[0].push_back(32'hA1B2_C3D4);
    src[0].push_back(32'h1122_3344);
    run_to(31);
    chk("two_count_pre", 64'(cnt2), 64'(2));
    capture();
    chk("two_lane0", 64'(cw[0][0]), 64'(32'hA1B2_C3D4));
    chk("two_lane1", 64'(cw[0][1]), 64'(32'h1122_3344));
    chk("two_valid", 64'(cv[0]), 64'(4'b0011));
    chk("two_count_post", 64'(cnt2), 64'(0));

    // Single word: lane 0 data, lane 1 idle, then an all-idle frame.
    step();
    src[0].push_back(32'hDEAD_BEEF);
    capture();
    chk("one_lane0", 64'(cw[0][0]), 64'(32'hDEAD_BEEF));
    chk("one_lane1", 64'(cw[0][1]), 64'(IdleW));
    chk("one_valid", 64'(cv[0]), 64'(4'b0001));
    capture();
    chk("one_after_lane0", 64'(cw[0][0]), 64'(IdleW));
    chk("one_after_valid", 64'(cv[0]), 64'(0));

    // A word pushed on the boundary edge waits a whole frame.
    src[0].push_back(32'h5A5A_0F0F);
    step();
    chk("bnd_push_state", 64'({8'(cnt2), lv2}), 64'({8'd1, 2'b00}));
    run_to(31);
    chk("bnd_push_held", 64'({8'(cnt2), lv2}), 64'({8'd1, 2'b00}));
    capture();
    chk("bnd_push_lane0", 64'(cw[0][0]), 64'(32'h5A5A_0F0F));
    chk("bnd_push_valid", 64'(cv[0]), 64'(4'b0001));

    // Fill to full with valid held high, then watch the boundary drain two.
    step();
    for (int j = 0; j < 10; j++) begin
      logic a0, a1;
      cyc(1'b0, tbl[j].v, tbl[j].d, 1'b0, 32'h0, a0, a1);
      chk($sformatf("fill_row%0d", j), 64'({if2.ready_out, 8'(cnt2)}),
          64'({tbl[j].rdy, tbl[j].cnt}));
    end
    src[0].push_back(32'h1111_0008);
    src[0].push_back(32'h1111_0009);
    run_to(31);
    chk("fill_full", 64'({if2.ready_out, 8'(cnt2)}), 64'({1'b0, 8'd8}));
    step();
    chk("fill_pop", 64'({if2.ready_out, 8'(cnt2)}), 64'({1'b1, 8'd6}));
    step();
    chk("fill_refill", 64'({if2.ready_out, 8'(cnt2)}), 64'({1'b1, 8'd7}));
    capture();
    chk("fill_lane0", 64'(cw[0][0]), 64'(32'h1111_0002));
    chk("fill_lane1", 64'(cw[0][1]), 64'(32'h1111_0003));
    chk("fill_valid", 64'(cv[0]), 64'(4'b0011));
    for (int i = 0; i < 100; i++) step();
    chk("fill_drained", 64'(cnt2), 64'(0));

    // Reset mid-frame with words buffered, then a four-lane stripe.
    run_to(0);
    for (int j = 0; j < 5; j++) src[0].push_back(32'h7700_0000 + 32'(j));
    run_to(13);
    chk("midrst_count_pre", 64'(cnt2), 64'(5));
    do_reset();
    chk("midrst_l2", 64'({if2.ready_out, 8'(cnt2), fs2, lv2, dout2}),
        64'({1'b1, 8'd0, 1'b1, 2'b00, 2'b11}));
    chk("midrst_l4", 64'({if4.ready_out, 8'(cnt4), fs4, lv4, dout4}),
        64'({1'b1, 8'd0, 1'b1, 4'b0000, 4'b1111}));
    src[1].push_back(32'hC0DE_0000);
    src[1].push_back(32'hC0DE_1111);
    src[1].push_back(32'hC0DE_2222);
    src[1].push_back(32'hC0DE_3333);
    capture();
    chk("l4_lane0", 64'(cw[1][0]), 64'(32'hC0DE_0000));
    chk("l4_lane1", 64'(cw[1][1]), 64'(32'hC0DE_1111));
    chk("l4_lane2", 64'(cw[1][2]), 64'(32'hC0DE_2222));
    chk("l4_lane3", 64'(cw[1][3]), 64'(32'hC0DE_3333));
    chk("l4_valid", 64'(cv[1]), 64'(4'b1111));
    chk("l2_after_rst_valid", 64'(cv[0]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
